// File: rtl/id_allocator.sv
// Transaction-ID allocator: FIFO free list (oldest-freed reused first) with optional
// illegal-free detection enabled by the ID_ALLOCATOR_DOUBLE_FREE_CHECK_EN macro.
module id_allocator #(
    parameter int ID_WIDTH  = 4,
    parameter int NUM_IDS   = 2**ID_WIDTH,
    parameter int CNT_WIDTH = $clog2(NUM_IDS+1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 alloc_req_i,
    output logic                 alloc_gnt_o,
    output logic [ID_WIDTH-1:0]  alloc_id_o,
    input  logic                 free_req_i,
    input  logic [ID_WIDTH-1:0]  free_id_i,
    output logic                 free_gnt_o,
    output logic [CNT_WIDTH-1:0] used_cnt_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 err_o
);

    localparam int PTR_W = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1;
    localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(NUM_IDS-1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(NUM_IDS);

    logic [ID_WIDTH-1:0]  fifo_mem [NUM_IDS];
    logic [PTR_W-1:0]     head_q;
    logic [PTR_W-1:0]     tail_q;
    logic [CNT_WIDTH-1:0] free_cnt_q;
    logic                 alloc_fire;
    logic                 push_en;
    logic                 err_q;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    // Handshakes: an alloc transfers when alloc_req_i && alloc_gnt_o, where the grant
    // and alloc_id_o come from registered state only; a free is always accepted
    // (free_gnt_o = 1) and transfers whenever free_req_i is high.
    assign alloc_gnt_o = (free_cnt_q != '0);
    assign alloc_id_o  = fifo_mem[head_q];
    assign alloc_fire  = alloc_req_i && alloc_gnt_o;
    assign free_gnt_o  = 1'b1;

`ifdef ID_ALLOCATOR_DOUBLE_FREE_CHECK_EN
    localparam logic [ID_WIDTH:0] ID_LIMIT = (ID_WIDTH+1)'(NUM_IDS);

    logic [2**ID_WIDTH-1:0] in_use_q;
    logic                   id_in_range;

    // The ID granted this cycle still reads as free, so a same-cycle free of it is rejected.
    assign id_in_range = ({1'b0, free_id_i} < ID_LIMIT);
    assign push_en     = free_req_i && id_in_range && in_use_q[free_id_i];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_use_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (alloc_fire) begin
                in_use_q[alloc_id_o] <= 1'b1;
            end
            if (push_en) begin
                in_use_q[free_id_i] <= 1'b0;
            end
            err_q <= free_req_i && !push_en;
        end
    end
`else
    // Caller guarantees legal frees; only keep the free count from overflowing.
    assign push_en = free_req_i && (free_cnt_q != FULL_CNT);
    assign err_q   = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_IDS; k++) begin
                fifo_mem[k] <= ID_WIDTH'(k);
            end
            head_q     <= '0;
            tail_q     <= '0;
            free_cnt_q <= FULL_CNT;
        end else begin
            if (push_en) begin
                fifo_mem[tail_q] <= free_id_i;
                tail_q           <= next_ptr(tail_q);
            end
            if (alloc_fire) begin
                head_q <= next_ptr(head_q);
            end
            case ({push_en, alloc_fire})
                2'b10:   free_cnt_q <= free_cnt_q + 1'b1;
                2'b01:   free_cnt_q <= free_cnt_q - 1'b1;
                default: free_cnt_q <= free_cnt_q;
            endcase
        end
    end

    assign used_cnt_o = FULL_CNT - free_cnt_q;
    assign full_o     = (free_cnt_q == '0);
    assign empty_o    = (free_cnt_q == FULL_CNT);
    assign err_o      = err_q;

endmodule

// File: tb/tb_id_allocator.sv
// Bench for id_allocator (ID_WIDTH=2, NUM_IDS=3): directed steps plus random traffic
// compared against a queue-based free-list model.
module tb_id_allocator;

  localparam int IDW = 2;
  localparam int N   = 3;
  localparam int CW  = $clog2(N+1);

`ifdef ID_ALLOCATOR_DOUBLE_FREE_CHECK_EN
  localparam bit CHECKED = 1'b1;
`else
  localparam bit CHECKED = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           alloc_req = 1'b0;
  logic           alloc_gnt;
  logic [IDW-1:0] alloc_id;
  logic           free_req = 1'b0;
  logic [IDW-1:0] free_id = '0;
  logic           free_gnt;
  logic [CW-1:0]  used_cnt;
  logic           full;
  logic           empty;
  logic           err;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: list of free IDs in reuse order, plus in-use flags
  logic [IDW-1:0] exp_q[$];
  bit             in_use_m[4];
  logic           exp_err;

  id_allocator #(.ID_WIDTH(IDW), .NUM_IDS(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .alloc_req_i(alloc_req), .alloc_gnt_o(alloc_gnt), .alloc_id_o(alloc_id),
    .free_req_i(free_req), .free_id_i(free_id), .free_gnt_o(free_gnt),
    .used_cnt_o(used_cnt), .full_o(full), .empty_o(empty), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back(IDW'(k));
    for (int k = 0; k < 4; k++) in_use_m[k] = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic model_update(input logic a, input logic f, input logic [IDW-1:0] id);
    bit had_free;
    bit legal;
    had_free = (exp_q.size() != 0);
    if (CHECKED) legal = f && (int'(id) < N) && in_use_m[id];
    else         legal = f && (exp_q.size() != N);
    exp_err = CHECKED && f && !legal;
    if (a && had_free) begin
      in_use_m[exp_q[0]] = 1'b1;
      void'(exp_q.pop_front());
    end
    if (legal) begin
      exp_q.push_back(id);
      in_use_m[id] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check("gnt", alloc_gnt, (exp_q.size() != 0));
    if (exp_q.size() != 0) check("id", alloc_id, exp_q[0]);
    check("used", used_cnt, N - exp_q.size());
    check("full", full, (exp_q.size() == 0));
    check("empty", empty, (exp_q.size() == N));
    check("err", err, exp_err);
    check("free_gnt", free_gnt, 1);
  endtask

  task automatic cycle(input logic a, input logic f, input logic [IDW-1:0] id);
    check_outputs();
    alloc_req = a;
    free_req  = f;
    free_id   = id;
    @(posedge clk);
    model_update(a, f, id);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic f, input logic [IDW-1:0] id);
    rst       = 1'b1;
    alloc_req = 1'b0;
    free_req  = f;
    free_id   = id;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst      = 1'b0;
    free_req = 1'b0;
  endtask

  initial begin
    logic [IDW-1:0] cand[$];
    logic           a;
    logic           f;
    logic [IDW-1:0] id;

    model_reset();
    @(posedge clk);
    do_reset(1'b0, '0);

    // reset state and sequential grants of IDs 0,1,2
    check("rst_gnt", alloc_gnt, 1);
    check("rst_empty", empty, 1);
    for (int i = 0; i < N; i++) begin
      check("t1_id", alloc_id, i);
      cycle(1'b1, 1'b0, '0);
    end
    check("t1_gnt", alloc_gnt, 0);
    check("t1_full", full, 1);
    check("t1_used", used_cnt, 3);
    cycle(1'b1, 1'b0, '0);

    // FIFO reuse order: free 1 then 0, re-grant 1 then 0
    cycle(1'b0, 1'b1, 2'd1);
    check("t2_used_a", used_cnt, 2);
    cycle(1'b0, 1'b1, 2'd0);
    check("t2_used_b", used_cnt, 1);
    check("t2_id_a", alloc_id, 1);
    cycle(1'b1, 1'b0, '0);
    check("t2_id_b", alloc_id, 0);
    cycle(1'b1, 1'b0, '0);
    check("t2_used_c", used_cnt, 3);

    // alloc + free on a full list: no bypass, ID 2 granted next cycle
    check("t3_gnt_full", alloc_gnt, 0);
    cycle(1'b1, 1'b1, 2'd2);
    check("t3_gnt", alloc_gnt, 1);
    check("t3_id", alloc_id, 2);
    cycle(1'b1, 1'b0, '0);

    // double free and out-of-range free
    cycle(1'b0, 1'b1, 2'd1);
    check("t4_err0", err, 0);
    if (CHECKED) begin
      cycle(1'b0, 1'b1, 2'd1);
      check("t4_err1", err, 1);
      check("t4_used1", used_cnt, 2);
      cycle(1'b0, 1'b1, 2'd3);
      check("t4_err2", err, 1);
      cycle(1'b0, 1'b0, '0);
      check("t4_err3", err, 0);
      check("t4_used2", used_cnt, 2);
    end

    // reset mid-operation with a free pending
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    do_reset(1'b1, 2'd0);
    check("t5_used", used_cnt, 0);
    check("t5_id", alloc_id, 0);
    check("t5_err", err, 0);

    // free of a never-allocated ID right after reset
    cycle(1'b0, 1'b1, 2'd0);
    check("t6_used", used_cnt, 0);
    check("t6_err", err, CHECKED);
    cycle(1'b0, 1'b0, '0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      a = 1'($urandom_range(0, 1));
      f = 1'($urandom_range(0, 1));
      cand.delete();
      for (int k = 0; k < N; k++) if (in_use_m[k]) cand.push_back(IDW'(k));
      if (CHECKED && ($urandom_range(0, 3) == 0 || cand.size() == 0)) begin
        id = IDW'($urandom_range(0, 3));
      end else if (cand.size() != 0) begin
        id = cand[$urandom_range(0, cand.size() - 1)];
      end else begin
        f  = 1'b0;
        id = '0;
      end
      if ($urandom_range(0, 99) == 0) begin
        check_outputs();
        do_reset(f, id);
      end else begin
        cycle(a, f, id);
      end
    end
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
